// File: rtl/hmc7044_spi_pkg.sv
// Shared definitions for the HMC7044 SPI responder: frame layout and FSM states.
package hmc7044_spi_pkg;

  // Default frame length: R/W + 2-bit multibyte + 13-bit address + 8-bit data.
  localparam int unsigned SPI_WIDTH_DEF = 24;
  localparam int unsigned DATA_W        = 8;

  // Bit positions inside the full frame (bit 23 is shifted in first).
  localparam int unsigned RW_BIT   = 23;
  localparam int unsigned MB_MSB   = 22;
  localparam int unsigned MB_LSB   = 21;
  localparam int unsigned ADDR_MSB = 20;
  localparam int unsigned ADDR_LSB = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RDATA,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/hmc7044_spi_responder_in_sync.sv
// Synchronizes spi_clk/cs/spi_mosi into clk and produces registered edge pulses.
// Ports:
//   clk, rst                    system clock, synchronous active-high reset
//   spi_clk, cs, spi_mosi       asynchronous SPI pins
//   sclk_rise_o/sclk_fall_o     one-cycle pulses on detected spi_clk edges
//   cs_rise_o/cs_fall_o         one-cycle pulses on detected cs edges
//   cs_level_o                  synchronized cs, one cycle ahead of cs_rise_o
//   mosi_o                      synchronized MOSI, aligned with sclk_rise_o
module spi_in_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_clk,
  input  logic cs,
  input  logic spi_mosi,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic cs_rise_o,
  output logic cs_fall_o,
  output logic cs_level_o,
  output logic mosi_o
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic sclk_prev_q, cs_prev_q, mosi_q;
  logic sclk_rise_q, sclk_fall_q, cs_rise_q, cs_fall_q;
  logic sclk_s, cs_s, mosi_s;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Chains keep tracking the pins through reset, so a frame still in flight
  // when reset releases is not mistaken for a fresh cs falling edge.
  always_ff @(posedge clk) begin
    sclk_sync_q <= SYNC_STAGES'({sclk_sync_q, spi_clk});
    cs_sync_q   <= SYNC_STAGES'({cs_sync_q, cs});
    mosi_sync_q <= SYNC_STAGES'({mosi_sync_q, spi_mosi});
    sclk_prev_q <= sclk_s;
    cs_prev_q   <= cs_s;
    mosi_q      <= mosi_s;
  end

  // Edge-detect register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
    end else begin
      sclk_rise_q <= sclk_s & ~sclk_prev_q;
      sclk_fall_q <= ~sclk_s & sclk_prev_q;
      cs_rise_q   <= cs_s & ~cs_prev_q;
      cs_fall_q   <= ~cs_s & cs_prev_q;
    end
  end

  assign sclk_rise_o = sclk_rise_q;
  assign sclk_fall_o = sclk_fall_q;
  assign cs_rise_o   = cs_rise_q;
  assign cs_fall_o   = cs_fall_q;
  assign cs_level_o  = cs_s;
  assign mosi_o      = mosi_q;

endmodule

// File: rtl/hmc7044_spi_responder.sv
// HMC7044-side SPI responder: decodes 24-bit frames, commits writes to a
// register image and a write strobe, serves reads on MISO.
// Ports:
//   clk, rst                    system clock, synchronous active-high reset
//   spi_clk, cs, spi_mosi       SPI mode-0 inputs from the master
//   spi_miso, spi_miso_oe       read data and its drive enable
//   wr_valid, wr_addr, wr_data  one-cycle write commit
//   frame_err                   one-cycle pulse on a malformed frame
//   frame_cnt                   count of good frames, wrapping
module hmc7044_spi_responder
  import hmc7044_spi_pkg::*;
#(
  parameter int unsigned SPI_WIDTH   = SPI_WIDTH_DEF,
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned REG_DEPTH   = 512,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              cs,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_err,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned CMD_BITS = SPI_WIDTH - DATA_W;
  localparam int unsigned SH_W     = CMD_BITS - 1;
  localparam int unsigned CNT_W    = $clog2(SPI_WIDTH + 2);
  localparam int unsigned IDX_W    = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, cs_lvl, mosi_s;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_in_sync (
    .clk         (clk),
    .rst         (rst),
    .spi_clk     (spi_clk),
    .cs          (cs),
    .spi_mosi    (spi_mosi),
    .sclk_rise_o (sclk_rise),
    .sclk_fall_o (sclk_fall),
    .cs_rise_o   (cs_rise),
    .cs_fall_o   (cs_fall),
    .cs_level_o  (cs_lvl),
    .mosi_o      (mosi_s)
  );

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SH_W-1:0]     shift_q, shift_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                miso_q, miso_d, oe_q, oe_d;
  logic                wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                ferr_q, ferr_d;
  logic [15:0]         fcnt_q, fcnt_d;
  logic                mem_we_c;
  logic [DATA_W-1:0]   mem_q [REG_DEPTH];

  // Command word as it stands once the current MOSI bit is included.
  logic [CMD_BITS-1:0] cmd_c;
  logic [ADDR_W-1:0]   cmd_addr_c;
  logic [DATA_W-1:0]   rd_byte_c;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < REG_DEPTH;
  endfunction

  assign cmd_c      = {shift_q, mosi_s};
  assign cmd_addr_c = ADDR_W'(cmd_c[ADDR_MSB-DATA_W:ADDR_LSB-DATA_W]);
  assign rd_byte_c  = in_range(cmd_addr_c) ? mem_q[cmd_addr_c[IDX_W-1:0]] : '0;

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    out_d      = out_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    ferr_d     = 1'b0;
    fcnt_d     = fcnt_q;
    mem_we_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_CMD;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      ST_CMD: begin
        if (cs_rise) begin
          ferr_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (sclk_rise) begin
          shift_d = cmd_c[SH_W-1:0];
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(CMD_BITS - 1)) begin
            addr_d = cmd_addr_c;
            if (cmd_c[MB_MSB-DATA_W:MB_LSB-DATA_W] != 2'b00) begin
              ferr_d  = 1'b1;
              state_d = ST_DRAIN;
            end else if (cmd_c[RW_BIT-DATA_W]) begin
              // Image read happens here so the shifter is ready before the next falling edge.
              out_d   = rd_byte_c;
              oe_d    = 1'b1;
              state_d = ST_RDATA;
            end else begin
              state_d = ST_WDATA;
            end
          end
        end
      end
      ST_WDATA, ST_RDATA: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
          if (cnt_q == CNT_W'(SPI_WIDTH)) begin
            fcnt_d = fcnt_q + 16'd1;
            if (state_q == ST_WDATA) begin
              wr_valid_d = 1'b1;
              wr_addr_d  = addr_q;
              wr_data_d  = shift_q[DATA_W-1:0];
              mem_we_c   = in_range(addr_q);
            end
          end else begin
            ferr_d = 1'b1;
          end
        end else if (sclk_rise) begin
          if (cnt_q == CNT_W'(SPI_WIDTH)) begin
            ferr_d  = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            shift_d = cmd_c[SH_W-1:0];
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall && state_q == ST_RDATA) begin
          miso_d = out_q[DATA_W-1];
          out_d  = {out_q[DATA_W-2:0], 1'b0};
        end
      end
      ST_DRAIN: begin
        if (cs_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // MISO is released as soon as synchronized cs goes high, one cycle ahead of cs_rise.
    if (state_d != ST_RDATA || cs_lvl) begin
      oe_d   = 1'b0;
      miso_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      out_q      <= '0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      ferr_q     <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      out_q      <= out_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      ferr_q     <= ferr_d;
      fcnt_q     <= fcnt_d;
    end
  end

  // Register image; written on the same edge that raises wr_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we_c) begin
      mem_q[addr_q[IDX_W-1:0]] <= shift_q[DATA_W-1:0];
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_err   = ferr_q;
  assign frame_cnt   = fcnt_q;

endmodule
